// File: rtl/frame_monitor.sv
// frame_monitor: receive-side checker for the sof/pri/eof framing pattern.
//
// Registers the three strobes once, walks each frame through
// IDLE -> SOF -> GAP -> PULSE -> EOF, measures every segment length and
// issues one verdict per frame (normal end, sof restart or timeout).
//
// Ports:
//   clk         clock
//   reset       synchronous, active-low reset
//   sof/pri/eof framing strobes from the generator
//   frame_done  one-cycle pulse when a verdict is issued
//   frame_ok    last verdict, 1 = no errors
//   pulse_cnt   pri pulses in the last frame (saturates at 255)
//   err         error flags of the last frame:
//               [0] sof width [1] gap [2] pri high [3] pri period
//               [4] pulse count [5] eof width [6] ordering [7] timeout
//   frames_ok   cumulative good frames (FRAME_MON_STATS_EN only, else 0)
//   frames_bad  cumulative bad frames  (FRAME_MON_STATS_EN only, else 0)
//
// Optional feature macro: FRAME_MON_STATS_EN builds the 16-bit saturating
// good/bad frame counters; without it both counter ports are tied to 0.
module frame_monitor #(
  parameter int SOF_LEN    = 4,
  parameter int GAP_MIN    = 48,
  parameter int GAP_MAX    = 54,
  parameter int PRI_HIGH   = 30,
  parameter int PRI_PERIOD = 100,
  parameter int PRI_COUNT  = 50,
  parameter int EOF_LEN    = 13,
  parameter int TOL        = 2,
  parameter int TIMEOUT    = 8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sof,
  input  logic        pri,
  input  logic        eof,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [7:0]  pulse_cnt,
  output logic [7:0]  err,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
);

  typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_GAP, ST_PULSE, ST_EOF} state_t;

  // Limits widened to 17 bits so they compare directly with run_len/pr_len.
  localparam logic [16:0] SOF_W  = 17'(SOF_LEN);
  localparam logic [16:0] GAP_LO = 17'(GAP_MIN);
  localparam logic [16:0] GAP_HI = 17'(GAP_MAX);
  localparam logic [16:0] HI_LO  = 17'(PRI_HIGH - TOL);
  localparam logic [16:0] HI_HI  = 17'(PRI_HIGH + TOL);
  localparam logic [16:0] PER_LO = 17'(PRI_PERIOD - TOL);
  localparam logic [16:0] PER_HI = 17'(PRI_PERIOD + TOL);
  localparam logic [16:0] EOF_LO = 17'(EOF_LEN - TOL);
  localparam logic [16:0] EOF_HI = 17'(EOF_LEN + TOL);
  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);
  localparam logic [7:0]  N_PRI  = 8'(PRI_COUNT);

  state_t      state;
  logic        sof_q, pri_q, eof_q;
  logic        sof_d, pri_d, eof_d;
  logic [15:0] cnt;      // run counter, cleared on every state change
  logic [15:0] pr_cnt;   // cycles since the last pri rise (1 on the rise)
  logic [7:0]  err_w;
  logic [7:0]  pulse_w;
  logic [7:0]  err_evt;

  logic sof_rise, sof_fall, pri_rise, pri_fall, eof_rise, eof_fall;
  logic active, timeout_hit;
  logic [16:0] run_len;  // length of the segment that started at the last state change
  logic [16:0] pr_len;

  assign sof_rise = sof_q & ~sof_d;
  assign sof_fall = ~sof_q & sof_d;
  assign pri_rise = pri_q & ~pri_d;
  assign pri_fall = ~pri_q & pri_d;
  assign eof_rise = eof_q & ~eof_d;
  assign eof_fall = ~eof_q & eof_d;

  assign active      = (state != ST_IDLE);
  assign timeout_hit = active && (cnt == TO_CNT);

  // The counter is cleared on the edge that detects the segment start, so
  // when the end is detected it holds one less than the pin-level width.
  assign run_len = {1'b0, cnt} + 17'd1;
  assign pr_len  = {1'b0, pr_cnt};

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Error flags raised by normal-transition events in the current cycle.
  always_comb begin
    err_evt = 8'h00;
    case (state)
      ST_SOF: begin
        err_evt[0] = sof_fall && (run_len != SOF_W);
        err_evt[6] = pri_rise | eof_rise;
      end
      ST_GAP: begin
        err_evt[1] = pri_rise && ((run_len < GAP_LO) || (run_len > GAP_HI));
      end
      ST_PULSE: begin
        err_evt[2] = pri_fall && ((pr_len < HI_LO) || (pr_len > HI_HI));
        err_evt[3] = pri_rise && ((pr_len < PER_LO) || (pr_len > PER_HI));
        err_evt[4] = eof_rise && (pulse_w != N_PRI);
      end
      ST_EOF: begin
        err_evt[5] = eof_fall && ((run_len < EOF_LO) || (run_len > EOF_HI));
      end
      default: err_evt = 8'h00;
    endcase
    if (active && pri_q && (sof_q || eof_q)) err_evt[6] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      sof_q      <= 1'b0;
      pri_q      <= 1'b0;
      eof_q      <= 1'b0;
      sof_d      <= 1'b0;
      pri_d      <= 1'b0;
      eof_d      <= 1'b0;
      cnt        <= 16'd0;
      pr_cnt     <= 16'd0;
      err_w      <= 8'h00;
      pulse_w    <= 8'd0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      pulse_cnt  <= 8'd0;
      err        <= 8'h00;
    end else begin
      sof_q      <= sof;
      pri_q      <= pri;
      eof_q      <= eof;
      sof_d      <= sof_q;
      pri_d      <= pri_q;
      eof_d      <= eof_q;
      frame_done <= 1'b0;
      pr_cnt     <= pri_rise ? 16'd1 : sat16(pr_cnt);

      if (active && sof_rise) begin
        // Restart: close the aborted frame and begin a fresh one this cycle.
        frame_done <= 1'b1;
        frame_ok   <= 1'b0;
        err        <= err_w | 8'h40;
        pulse_cnt  <= pulse_w;
        state      <= ST_SOF;
        cnt        <= 16'd0;
        err_w      <= 8'h00;
        pulse_w    <= 8'd0;
      end else if (timeout_hit) begin
        frame_done <= 1'b1;
        frame_ok   <= 1'b0;
        err        <= err_w | 8'h80;
        pulse_cnt  <= pulse_w;
        state      <= ST_IDLE;
        cnt        <= 16'd0;
      end else begin
        err_w <= err_w | err_evt;
        cnt   <= sat16(cnt);
        case (state)
          ST_IDLE: begin
            if (sof_rise) begin
              state   <= ST_SOF;
              cnt     <= 16'd0;
              err_w   <= 8'h00;
              pulse_w <= 8'd0;
            end
          end
          ST_SOF: begin
            if (sof_fall) begin
              state <= ST_GAP;
              cnt   <= 16'd0;
            end
          end
          ST_GAP: begin
            if (pri_rise) begin
              state   <= ST_PULSE;
              cnt     <= 16'd0;
              pulse_w <= 8'd1;
            end else if (eof_rise) begin
              state <= ST_EOF;
              cnt   <= 16'd0;
            end
          end
          ST_PULSE: begin
            if (pri_rise && (pulse_w != 8'hFF)) pulse_w <= pulse_w + 8'd1;
            if (eof_rise) begin
              state <= ST_EOF;
              cnt   <= 16'd0;
            end
          end
          ST_EOF: begin
            if (eof_fall) begin
              frame_done <= 1'b1;
              frame_ok   <= ((err_w | err_evt) == 8'h00);
              err        <= err_w | err_evt;
              pulse_cnt  <= pulse_w;
              state      <= ST_IDLE;
              cnt        <= 16'd0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef FRAME_MON_STATS_EN
  // Counters follow the registered verdict, so they update one cycle
  // after frame_done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frames_ok  <= 16'd0;
      frames_bad <= 16'd0;
    end else if (frame_done) begin
      if (frame_ok) begin
        if (frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
      end else begin
        if (frames_bad != 16'hFFFF) frames_bad <= frames_bad + 16'd1;
      end
    end
  end
`else
  assign frames_ok  = 16'd0;
  assign frames_bad = 16'd0;
`endif

endmodule

// File: tb/tb_frame_monitor.sv
// Testbench for frame_monitor: directed and randomized frames described as
// segment lengths; the expected verdict is derived from those lengths.
module tb_frame_monitor;

`ifdef FRAME_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sof = 1'b0;
  logic        pri = 1'b0;
  logic        eof = 1'b0;
  logic        frame_done;
  logic        frame_ok;
  logic [7:0]  pulse_cnt;
  logic [7:0]  err;
  logic [15:0] frames_ok;
  logic [15:0] frames_bad;

  frame_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .sof        (sof),
    .pri        (pri),
    .eof        (eof),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .pulse_cnt  (pulse_cnt),
    .err        (err),
    .frames_ok  (frames_ok),
    .frames_bad (frames_bad)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int exp_good = 0;
  int exp_bad = 0;
  int hi_a[256];
  int per_a[256];

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic p, input logic e);
    sof = s;
    pri = p;
    eof = e;
    @(posedge clk);
    #1;
  endtask

  task automatic set_nominal();
    for (int k = 0; k < 256; k++) begin
      hi_a[k]  = 30;
      per_a[k] = 100;
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_fok"}, {16'd0, frames_ok},  STATS ? exp_good : 0);
    check({tag, "_fbad"}, {16'd0, frames_bad}, STATS ? exp_bad : 0);
  endtask

  // Reference verdict computed from the frame's segment lengths.
  function automatic logic [7:0] model_err(input int sof_w, input int gap, input int n, input int eof_w);
    logic [7:0] e;
    e = 8'h00;
    if (sof_w != 4) e[0] = 1'b1;
    if (n > 0 && (gap < 48 || gap > 54)) e[1] = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (hi_a[k] < 28 || hi_a[k] > 32) e[2] = 1'b1;
      if (k < n - 1 && (per_a[k] < 98 || per_a[k] > 102)) e[3] = 1'b1;
    end
    if (n != 50) e[4] = 1'b1;
    if (eof_w < 11 || eof_w > 15) e[5] = 1'b1;
    return e;
  endfunction

  task automatic record(input string name, input logic [7:0] exp_e, input int exp_n);
    check({name, "_done"}, {31'd0, frame_done}, 1);
    check({name, "_ok"}, {31'd0, frame_ok}, (exp_e == 8'h00) ? 1 : 0);
    check({name, "_pcnt"}, {24'd0, pulse_cnt}, exp_n);
    check({name, "_err"}, {24'd0, err}, {24'd0, exp_e});
    if (exp_e == 8'h00) exp_good++;
    else exp_bad++;
    $display("frame %-10s ok=%0b pulses=%0d err=0x%02h (exp err=0x%02h pulses=%0d)",
             name, frame_ok, pulse_cnt, err, exp_e, exp_n);
  endtask

  // Drives a full frame (sof_pre sof cycles already on the pins) and
  // checks verdict timing, contents, single frame_done and statistics.
  task automatic send_frame(input string name, input int sof_pre, input int sof_w,
                            input int gap, input int n, input int eof_w);
    int d0;
    d0 = done_cnt;
    for (int i = sof_pre; i < sof_w; i++) cyc(1, 0, 0);
    for (int i = 0; i < gap; i++) cyc(0, 0, 0);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < hi_a[k]; i++) cyc(0, 1, 0);
      for (int i = 0; i < ((k < n - 1) ? per_a[k] - hi_a[k] : 20); i++) cyc(0, 0, 0);
    end
    for (int i = 0; i < eof_w; i++) cyc(0, 0, 1);
    cyc(0, 0, 0);
    check({name, "_early"}, {31'd0, frame_done}, 0);
    cyc(0, 0, 0);
    record(name, model_err(sof_w, gap, n, eof_w), n);
    cyc(0, 0, 0);
    check({name, "_once"}, done_cnt - d0, 1);
    check_stats(name);
  endtask

  task automatic prefix(input int np);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    for (int i = 0; i < 50; i++) cyc(0, 0, 0);
    for (int k = 0; k < np; k++) begin
      for (int i = 0; i < 30; i++) cyc(0, 1, 0);
      for (int i = 0; i < 70; i++) cyc(0, 0, 0);
    end
  endtask

  initial begin
    int got;
    int d0;
    int sw, gp, np, ew;

    // Reset state
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("rst_done", {31'd0, frame_done}, 0);
    check("rst_ok", {31'd0, frame_ok}, 0);
    check("rst_pcnt", {24'd0, pulse_cnt}, 0);
    check("rst_err", {24'd0, err}, 0);
    check_stats("rst");
    reset = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    set_nominal();
    send_frame("nominal", 0, 4, 50, 50, 13);
    send_frame("sof5_n49", 0, 5, 50, 49, 13);
    hi_a[9] = 33;
    per_a[19] = 103;
    send_frame("hi_per", 0, 4, 50, 50, 13);
    set_nominal();
    hi_a[4] = 32;
    per_a[4] = 102;
    send_frame("in_tol", 0, 4, 50, 50, 13);
    set_nominal();

    // Restart during pulse 12
    prefix(11);
    for (int i = 0; i < 30; i++) cyc(0, 1, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0);
    cyc(1, 0, 0);
    check("restart_early", {31'd0, frame_done}, 0);
    cyc(1, 0, 0);
    record("restart", 8'h40, 12);
    cyc(1, 0, 0);
    check_stats("restart");
    send_frame("after_rst", 3, 4, 50, 50, 13);

    // Timeout in GAP
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    got = -1;
    for (int k = 1; k <= 9000; k++) begin
      cyc(0, 0, 0);
      if (frame_done === 1'b1) begin
        got = k;
        break;
      end
    end
    check("to_lat", (got >= 8000 && got <= 8006) ? 1 : 0, 1);
    record("timeout", 8'h80, 0);
    cyc(0, 0, 0);
    check_stats("timeout");

    // Randomized frames
    for (int f = 0; f < 5; f++) begin
      set_nominal();
      sw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 6)) : 4;
      gp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(44, 58)) : int'($urandom_range(48, 54));
      np = ($urandom_range(0, 3) == 0) ? int'($urandom_range(45, 55)) : 50;
      ew = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 17)) : int'($urandom_range(11, 15));
      for (int k = 0; k < np; k++) begin
        hi_a[k]  = ($urandom_range(0, 40) == 0) ? int'($urandom_range(25, 35)) : int'($urandom_range(28, 32));
        per_a[k] = ($urandom_range(0, 40) == 0) ? int'($urandom_range(95, 105)) : int'($urandom_range(98, 102));
      end
      send_frame($sformatf("rand%0d", f), 0, sw, gp, np, ew);
    end
    set_nominal();

    // Reset in the middle of PULSE
    prefix(5);
    d0 = done_cnt;
    reset = 1'b0;
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    check("mid_done", {31'd0, frame_done}, 0);
    check("mid_ok", {31'd0, frame_ok}, 0);
    check("mid_pcnt", {24'd0, pulse_cnt}, 0);
    check("mid_err", {24'd0, err}, 0);
    exp_good = 0;
    exp_bad = 0;
    check_stats("mid");
    reset = 1'b1;
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);
    check("mid_nodone", done_cnt - d0, 0);
    send_frame("post_rst", 0, 4, 50, 50, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
